// File: rtl/adc_channel_sequencer.sv
// adc_channel_sequencer
//   Round-robin scanner for the MAX10 modular ADC Avalon-ST command/response
//   pair. One command is outstanding at a time. The response is matched to the
//   command by channel number and stored into a 16-bit lane per scanned
//   channel. Every command has its own watchdog.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   enable              1 = run continuous sweeps
//   ch_mask[NUM_CH]     bit i enables lane i (ADC channel CH_BASE+i)
//   cmd_valid/channel/sop/eop, cmd_ready       Avalon-ST command source
//   rsp_valid/channel/data                     Avalon-ST response sink
//   adc_data[16*NUM_CH] lane i at [16*i+15:16*i]
//   sample_stb          1-cycle pulse when a lane is written
//   sweep_done          1-cycle pulse when the scan pointer wraps
//   timeout_err         sticky watchdog flag, cleared only by rst
//
// Build option
//   ADC_SEQ_AVG_EN      lanes become IIR filters (shift AVG_SHIFT), each lane
//                       is loaded directly by its first sample after reset.
//                       When undefined, lanes store {4'b0, rsp_data}.

module adc_channel_sequencer #(
  parameter int NUM_CH    = 8,
  parameter int CH_BASE   = 1,
  parameter int TIMEOUT   = 4095,
  parameter int AVG_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    ch_mask,
  output logic                 cmd_valid,
  output logic [4:0]           cmd_channel,
  output logic                 cmd_sop,
  output logic                 cmd_eop,
  input  logic                 cmd_ready,
  input  logic                 rsp_valid,
  input  logic [4:0]           rsp_channel,
  input  logic [11:0]          rsp_data,
  output logic [16*NUM_CH-1:0] adc_data,
  output logic                 sample_stb,
  output logic                 sweep_done,
  output logic                 timeout_err
);

  localparam int LW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // ptr holds sel+1 unwrapped (0..NUM_CH) so a wrap is visible to SEL.
  localparam int PW = $clog2(NUM_CH + 1);
  // Counter runs 0..TIMEOUT-1 while waiting.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEL   = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [LW-1:0]        sel_q, sel_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [4:0]           cmd_channel_q, cmd_channel_d;
  logic                 sample_stb_q, sample_stb_d;
  logic                 sweep_done_q, sweep_done_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [16*NUM_CH-1:0] adc_data_q, adc_data_d;

  logic                 found_s;
  logic [LW-1:0]        pick_s;
  logic                 wrap_s;
  logic                 store_s;
  logic [15:0]          new_lane_s;

  // Next enabled lane at or after ptr, wrapping; wrap_s flags a pass over the last lane.
  always_comb begin
    int start_v;
    int idx_v;
    found_s = 1'b0;
    pick_s  = '0;
    wrap_s  = 1'b0;
    start_v = (int'(ptr_q) >= NUM_CH) ? 0 : int'(ptr_q);
    idx_v   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_v = ((start_v + k) >= NUM_CH) ? (start_v + k - NUM_CH) : (start_v + k);
      if (!found_s && ch_mask[LW'(idx_v)]) begin
        found_s = 1'b1;
        pick_s  = LW'(idx_v);
        wrap_s  = (int'(ptr_q) >= NUM_CH) || (idx_v < start_v);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Sequencer FSM: next state, pointer, watchdog and pulse outputs.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    cmd_channel_d = cmd_channel_q;
    sample_stb_d  = 1'b0;
    sweep_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    store_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && (ch_mask != '0)) begin
          state_d = ST_SEL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEL: begin
        if (!enable || !found_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d       = ST_ISSUE;
          sel_d         = pick_s;
          cmd_channel_d = 5'(CH_BASE) + 5'(pick_s);
          sweep_done_d  = wrap_s;
        end
      end
      ST_ISSUE: begin
        // Avalon-ST: the command is held until accepted, never withdrawn.
        if (cmd_ready) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // A matching response beats a simultaneous watchdog expiry.
        if (rsp_valid && (rsp_channel == cmd_channel_q)) begin
          store_s      = 1'b1;
          sample_stb_d = 1'b1;
          ptr_d        = PW'(sel_q) + PW'(1);
          state_d      = ST_SEL;
        end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          ptr_d         = PW'(sel_q) + PW'(1);
          state_d       = ST_SEL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_valid_d = (state_d == ST_ISSUE);
  end

`ifdef ADC_SEQ_AVG_EN
  logic [NUM_CH-1:0] primed_q, primed_d;
  logic [15:0]       cur_lane_s;
  logic signed [16:0] diff_s;
  logic signed [16:0] step_s;

  // IIR update; an unprimed lane takes the scaled sample directly.
  always_comb begin
    cur_lane_s = adc_data_q[{sel_q, 4'b0000} +: 16];
    diff_s     = $signed({1'b0, rsp_data, 4'b0000}) - $signed({1'b0, cur_lane_s});
    step_s     = diff_s >>> AVG_SHIFT;
    if (primed_q[sel_q]) begin
      new_lane_s = cur_lane_s + step_s[15:0];
    end else begin
      new_lane_s = {rsp_data, 4'b0000};
    end
    primed_d = primed_q;
    if (store_s) begin
      primed_d[sel_q] = 1'b1;
    end else begin
      primed_d = primed_q;
    end
  end

  // Per-lane primed flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q <= '0;
    end else begin
      primed_q <= primed_d;
    end
  end
`else
  // Raw zero-extended lane value.
  always_comb begin
    new_lane_s = {4'b0000, rsp_data};
  end
`endif

  // Lane write for the matched response.
  always_comb begin
    adc_data_d = adc_data_q;
    if (store_s) begin
      adc_data_d[{sel_q, 4'b0000} +: 16] = new_lane_s;
    end else begin
      adc_data_d = adc_data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_channel_q <= 5'd0;
      sample_stb_q  <= 1'b0;
      sweep_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      adc_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_channel_q <= cmd_channel_d;
      sample_stb_q  <= sample_stb_d;
      sweep_done_q  <= sweep_done_d;
      timeout_err_q <= timeout_err_d;
      adc_data_q    <= adc_data_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_sop     = cmd_valid_q;
  assign cmd_eop     = cmd_valid_q;
  assign cmd_channel = cmd_channel_q;
  assign sample_stb  = sample_stb_q;
  assign sweep_done  = sweep_done_q;
  assign timeout_err = timeout_err_q;
  assign adc_data    = adc_data_q;

endmodule
